hazard_forward_unit: RTL and testbench

//  Parametrised successor to the single-path EX/MEM forwarding unit.

---
 rtl/fu_pkg.sv | 15 +
 rtl/fu_operand_match.sv | 46 ++++
 rtl/hazard_forward_unit.sv | 128 ++++++++++++
 tb/tb_hazard_forward_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fu_pkg.sv
// Shared constants and types for hazard_forward_unit.
//   FWD_* : operand forward-select encodings driven on fwd_sel
//   fsm_state_e : load-use stall FSM states
package fu_pkg;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;
  localparam logic [1:0] FWD_MEMWB   = 2'b01;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_STALL = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/fu_operand_match.sv
// Forward-select for one ALU operand: compares its source address against the
// EX/MEM and MEM/WB destinations; EX/MEM (younger) wins when both match.
// Optional macro FU_ZERO_REG_EN: destination 0 never forwards.
// Ports:
//   src          in  source register address of the EX operand
//   ex_mem_wr    in  EX/MEM writes the register file
//   ex_mem_rd    in  EX/MEM destination
//   mem_wb_wr    in  MEM/WB writes the register file
//   mem_wb_rd    in  MEM/WB destination
//   sel_c        out combinational 2-bit forward select
module fu_operand_match
  import fu_pkg::*;
#(
  parameter int unsigned REG_AW = 4
) (
  input  logic [REG_AW-1:0] src,
  input  logic              ex_mem_wr,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic              mem_wb_wr,
  input  logic [REG_AW-1:0] mem_wb_rd,
  output logic [1:0]        sel_c
);

  logic ex_ok;
  logic wb_ok;

  // Qualify each stage's write; register 0 is not a real destination when hardwired
`ifdef FU_ZERO_REG_EN
  assign ex_ok = ex_mem_wr && (ex_mem_rd != '0);
  assign wb_ok = mem_wb_wr && (mem_wb_rd != '0);
`else
  assign ex_ok = ex_mem_wr;
  assign wb_ok = mem_wb_wr;
`endif

  // Priority select, youngest producer first
  always_comb begin
    sel_c = FWD_REGFILE;
    if (ex_ok && (ex_mem_rd == src)) begin
      sel_c = FWD_EXMEM;
    end else if (wb_ok && (mem_wb_rd == src)) begin
      sel_c = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand forwarding plus load-use hazard stall control.
// Optional macro FU_ZERO_REG_EN: register 0 hardwired zero (never forwards,
// never raises a load-use hazard).
// Ports:
//   clk, rst_n           clock, async active-low reset
//   if_id_src/_used      sources of the ID instruction and their read enables
//   id_ex_src            sources of the EX instruction (forwarding compare)
//   id_ex_rd/_memRead    EX destination and load flag (hazard compare)
//   ex_mem_*, mem_wb_*   write enables and destinations of the later stages
//   flush                aborts any stall in the same cycle
//   fwd_sel              per-operand forward select (2 bits per operand)
//   stall_pc/_if_id      hold PC and IF/ID
//   bubble_id_ex         insert NOP into ID/EX
//   stall_active         registered: FSM is in STALL
module hazard_forward_unit
  import fu_pkg::*;
#(
  parameter int unsigned REG_AW     = 4,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned LOAD_STALL = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] if_id_src,
  input  logic [NUM_SRC-1:0]        if_id_src_used,
  input  logic [NUM_SRC*REG_AW-1:0] id_ex_src,
  input  logic [REG_AW-1:0]         id_ex_rd,
  input  logic                      id_ex_memRead,
  input  logic                      ex_mem_regWrite,
  input  logic [REG_AW-1:0]         ex_mem_rd,
  input  logic                      mem_wb_regWrite,
  input  logic [REG_AW-1:0]         mem_wb_rd,
  input  logic                      flush,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      stall_pc,
  output logic                      stall_if_id,
  output logic                      bubble_id_ex,
  output logic                      stall_active
);

  localparam int unsigned CNT_W = (LOAD_STALL > 0) ? $clog2(LOAD_STALL + 1) : 1;

  logic [2*NUM_SRC-1:0] sel_raw;
  logic                 src_hit;
  logic                 rd_ok;
  logic                 hazard;
  logic                 stall_c;
  fsm_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // One comparator per operand
  for (genvar g = 0; g < int'(NUM_SRC); g++) begin : g_match
    fu_operand_match #(.REG_AW(REG_AW)) u_match (
      .src       (id_ex_src[g*REG_AW +: REG_AW]),
      .ex_mem_wr (ex_mem_regWrite),
      .ex_mem_rd (ex_mem_rd),
      .mem_wb_wr (mem_wb_regWrite),
      .mem_wb_rd (mem_wb_rd),
      .sel_c     (sel_raw[2*g +: 2])
    );
  end

  // Does any used ID source read the EX load's destination
  always_comb begin
    src_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (if_id_src_used[i] && (if_id_src[i*REG_AW +: REG_AW] == id_ex_rd)) begin
        src_hit = 1'b1;
      end
    end
  end

`ifdef FU_ZERO_REG_EN
  assign rd_ok = (id_ex_rd != '0);
`else
  assign rd_ok = 1'b1;
`endif

  assign hazard = (LOAD_STALL != 0) && id_ex_memRead && src_hit && rd_ok;

  // Stall FSM: first bubble is raised from IDLE, the remaining ones from STALL
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_c = hazard && !flush;
        if (stall_c && (LOAD_STALL > 1)) begin
          state_d = S_STALL;
          cnt_d   = CNT_W'(LOAD_STALL - 1);
        end
      end
      S_STALL: begin
        // ID is frozen here, so new hazards are not re-evaluated
        stall_c = !flush;
        cnt_d   = cnt_q - CNT_W'(1);
        if (flush || (cnt_q == CNT_W'(1))) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced quiet while reset is held
  assign fwd_sel      = rst_n ? sel_raw : '0;
  assign stall_pc     = stall_c && rst_n;
  assign stall_if_id  = stall_c && rst_n;
  assign bubble_id_ex = stall_c && rst_n;
  assign stall_active = (state_q == S_STALL);

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: two instances (LOAD_STALL = 1 and 3) share
// stimulus; a reference model tracks remaining stall cycles as a plain integer.
module tb_hazard_forward_unit;

  localparam int unsigned AW = 4;
  localparam int unsigned NS = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NS*AW-1:0]  if_id_src;
  logic [NS-1:0]     if_id_src_used;
  logic [NS*AW-1:0]  id_ex_src;
  logic [AW-1:0]     id_ex_rd;
  logic              id_ex_memRead;
  logic              ex_mem_regWrite;
  logic [AW-1:0]     ex_mem_rd;
  logic              mem_wb_regWrite;
  logic [AW-1:0]     mem_wb_rd;
  logic              flush;

  logic [2*NS-1:0]   fwd1, fwd3;
  logic              spc1, sif1, bub1, act1;
  logic              spc3, sif3, bub3, act3;

  int total = 0;
  int bad   = 0;
  int rem1  = 0;
  int rem3  = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  hazard_forward_unit #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_STALL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .if_id_src(if_id_src), .if_id_src_used(if_id_src_used),
    .id_ex_src(id_ex_src), .id_ex_rd(id_ex_rd), .id_ex_memRead(id_ex_memRead),
    .ex_mem_regWrite(ex_mem_regWrite), .ex_mem_rd(ex_mem_rd),
    .mem_wb_regWrite(mem_wb_regWrite), .mem_wb_rd(mem_wb_rd), .flush(flush),
    .fwd_sel(fwd1), .stall_pc(spc1), .stall_if_id(sif1), .bubble_id_ex(bub1),
    .stall_active(act1)
  );

  hazard_forward_unit #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_STALL(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .if_id_src(if_id_src), .if_id_src_used(if_id_src_used),
    .id_ex_src(id_ex_src), .id_ex_rd(id_ex_rd), .id_ex_memRead(id_ex_memRead),
    .ex_mem_regWrite(ex_mem_regWrite), .ex_mem_rd(ex_mem_rd),
    .mem_wb_regWrite(mem_wb_regWrite), .mem_wb_rd(mem_wb_rd), .flush(flush),
    .fwd_sel(fwd3), .stall_pc(spc3), .stall_if_id(sif3), .bubble_id_ex(bub3),
    .stall_active(act3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit real_dest(input logic [AW-1:0] rd);
`ifdef FU_ZERO_REG_EN
    return rd != 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [1:0] model_sel(input int i);
    logic [AW-1:0] s;
    s = id_ex_src[i*AW +: AW];
    if (ex_mem_regWrite && real_dest(ex_mem_rd) && ex_mem_rd == s) return 2'b10;
    if (mem_wb_regWrite && real_dest(mem_wb_rd) && mem_wb_rd == s) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit model_hazard();
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < int'(NS); i++)
      if (if_id_src_used[i] && if_id_src[i*AW +: AW] == id_ex_rd) hit = 1'b1;
    return id_ex_memRead && hit && real_dest(id_ex_rd);
  endfunction

  // Stall cycles still owed after the current one
  function automatic int next_rem(input int r, input int lat);
    if (r > 0) return flush ? 0 : r - 1;
    if (lat > 0 && model_hazard() && !flush) return lat - 1;
    return 0;
  endfunction

  function automatic bit exp_stall(input int r);
    return rst_n && !flush && (r > 0 || model_hazard());
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem1 <= 0;
      rem3 <= 0;
    end else begin
      rem1 <= next_rem(rem1, 1);
      rem3 <= next_rem(rem3, 3);
    end
  end

  // Compare process: every falling edge, both instances against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < int'(NS); i++) begin
        check("fwd_l1", 32'(fwd1[2*i +: 2]), rst_n ? 32'(model_sel(i)) : 32'd0);
        check("fwd_l3", 32'(fwd3[2*i +: 2]), rst_n ? 32'(model_sel(i)) : 32'd0);
      end
      check("stall_l1", {29'd0, spc1, sif1, bub1}, exp_stall(rem1) ? 32'd7 : 32'd0);
      check("stall_l3", {29'd0, spc3, sif3, bub3}, exp_stall(rem3) ? 32'd7 : 32'd0);
      check("active_l1", 32'(act1), 32'(rst_n && rem1 > 0));
      check("active_l3", 32'(act3), 32'(rst_n && rem3 > 0));
    end
  end

  task automatic idle_inputs();
    if_id_src = '0; if_id_src_used = '0; id_ex_src = '0; id_ex_rd = '0;
    id_ex_memRead = 1'b0; ex_mem_regWrite = 1'b0; ex_mem_rd = '0;
    mem_wb_regWrite = 1'b0; mem_wb_rd = '0; flush = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_hazard();
    idle_inputs();
    id_ex_memRead = 1'b1; id_ex_rd = 4'd7;
    if_id_src = {4'd2, 4'd7}; if_id_src_used = 2'b01;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [3:0] rd_pick;
    rst_n = 1'b0;
    idle_inputs();
    // Matching inputs during reset must still give quiet outputs
    ex_mem_regWrite = 1'b1; ex_mem_rd = 4'd5; id_ex_src = {4'd0, 4'd5};
    id_ex_memRead = 1'b1; id_ex_rd = 4'd5; if_id_src = {4'd0, 4'd5}; if_id_src_used = 2'b01;
    #2;
    check("reset_fwd", 32'(fwd3), 32'd0);
    check("reset_stall", {28'd0, spc1, spc3, act1, act3}, 32'd0);
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_inputs();

    // Both stages match operand 0: EX/MEM wins
    next_cycle();
    ex_mem_regWrite = 1'b1; ex_mem_rd = 4'd5; mem_wb_regWrite = 1'b1; mem_wb_rd = 4'd5;
    id_ex_src = {4'd9, 4'd5};
    @(negedge clk);
    check("prio_exmem", 32'(fwd1), 32'b0010);

    // Only MEM/WB valid, matches operand 1
    next_cycle();
    idle_inputs();
    mem_wb_regWrite = 1'b1; mem_wb_rd = 4'd3; id_ex_src = {4'd3, 4'd6};
    @(negedge clk);
    check("memwb_op1", 32'(fwd3), 32'b0100);

    // Load-use hazard then a bubble in ID/EX
    next_cycle();
    load_hazard();
    @(negedge clk);
    check("l1_c1_stall", {30'd0, spc1, act1}, 32'b10);
    check("l3_c1_stall", {30'd0, spc3, act3}, 32'b10);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("l1_c2_stall", {30'd0, spc1, act1}, 32'b00);
    check("l3_c2_stall", {30'd0, spc3, act3}, 32'b11);
    next_cycle();
    @(negedge clk);
    check("l3_c3_stall", {30'd0, spc3, act3}, 32'b11);
    next_cycle();
    @(negedge clk);
    check("l3_c4_idle", {30'd0, spc3, act3}, 32'b00);

    // Flush in the second stall cycle
    next_cycle();
    load_hazard();
    @(negedge clk);
    check("fl_c1", {30'd0, spc3, act3}, 32'b10);
    next_cycle();
    idle_inputs();
    flush = 1'b1;
    @(negedge clk);
    check("fl_c2", {30'd0, spc3, act3}, 32'b01);
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    check("fl_c3", {30'd0, spc3, act3}, 32'b00);

    // Asynchronous reset in mid-stall
    next_cycle();
    load_hazard();
    next_cycle();
    idle_inputs();
    ex_mem_regWrite = 1'b1; ex_mem_rd = 4'd4; id_ex_src = {4'd0, 4'd4};
    @(negedge clk);
    check("rs_pre", {30'd0, spc3, act3}, 32'b11);
    #1 rst_n = 1'b0;
    #1;
    check("rs_now_stall", {30'd0, spc3, act3}, 32'b00);
    check("rs_now_fwd", 32'(fwd3), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rs_after", {30'd0, spc3, act3}, 32'b00);
    check("rs_after_fwd", 32'(fwd3), 32'b0010);

    // Register 0 as destination
    next_cycle();
    idle_inputs();
    ex_mem_regWrite = 1'b1; ex_mem_rd = 4'd0; id_ex_src = {4'd1, 4'd0};
    id_ex_memRead = 1'b1; id_ex_rd = 4'd0; if_id_src = {4'd1, 4'd0}; if_id_src_used = 2'b01;
    @(negedge clk);
`ifdef FU_ZERO_REG_EN
    check("zero_fwd", 32'(fwd1), 32'b0000);
    check("zero_stall", 32'(spc1), 32'd0);
`else
    check("zero_fwd", 32'(fwd1), 32'b0010);
    check("zero_stall", 32'(spc1), 32'd1);
`endif
    next_cycle();
    idle_inputs();
    repeat (3) next_cycle();

    // Randomized traffic with occasional flushes and reset pulses
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      rst_n = 1'b1;
      if_id_src       = NS*AW'($urandom());
      if_id_src_used  = NS'($urandom());
      id_ex_src       = NS*AW'($urandom());
      ex_mem_regWrite = 1'($urandom());
      mem_wb_regWrite = 1'($urandom());
      ex_mem_rd       = AW'($urandom_range(0, 7));
      mem_wb_rd       = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) ex_mem_rd = id_ex_src[AW-1:0];
      if ($urandom_range(0, 1) == 0) mem_wb_rd = id_ex_src[2*AW-1:AW];
      id_ex_memRead   = ($urandom_range(0, 2) == 0);
      rd_pick         = AW'($urandom());
      id_ex_rd        = ($urandom_range(0, 1) == 0) ? if_id_src[AW-1:0] : rd_pick;
      flush           = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
      end
    end
    next_cycle();
    rst_n = 1'b1;
    idle_inputs();
    @(negedge clk);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
